// File: rtl/shift_deser_pkg.sv
// Shared state encoding and default parameters for the shift deserializer.
package shift_deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_SIZE    = 3;
    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/shift_deser_timer.sv
// Idle-cycle counter for partial-frame abort; expired flags the TIMEOUT-th
// consecutive enabled cycle.
module shift_deser_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_count;

    assign expired = en && (r_count == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Collects SIZE words of WIDTH bits into one frame; slot order chosen by dir
// on the first word. Partial-frame timeout is built only with SHIFT_DESER_TIMEOUT_EN.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SIZE    = DEF_SIZE,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    dir,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*SIZE-1:0]   dout,
    output logic                    frame_abort
);

    localparam int unsigned CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_dir;
    logic [WIDTH*SIZE-1:0]   r_dout;
    logic                    r_out_valid;
    logic                    r_abort;

    logic                    w_in_ready;
    logic                    w_in_beat;
    logic                    w_dir_eff;
    logic [CW-1:0]           w_slot;
    logic                    w_abort;

    assign w_in_ready = ce && (r_state != FULL);
    assign w_in_beat  = w_in_ready && in_valid;
    // The first word of a frame uses the live dir; later words use the latched copy.
    assign w_dir_eff  = (r_state == IDLE) ? dir : r_dir;
    assign w_slot     = w_dir_eff ? r_cnt : (LAST - r_cnt);

`ifdef SHIFT_DESER_TIMEOUT_EN
    logic w_timer_en;
    logic w_timer_clear;

    assign w_timer_en    = ce && (r_state == FILL) && !w_in_beat;
    assign w_timer_clear = w_in_beat || w_abort;

    shift_deser_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (w_timer_en),
        .clear   (w_timer_clear),
        .expired (w_abort)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (ce) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_in_beat) begin
                            r_dir                         <= dir;
                            r_dout[w_slot*WIDTH +: WIDTH] <= data_in;
                            r_cnt                         <= CW'(1);
                            r_state                       <= FILL;
                        end
                    end
                    FILL: begin
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_dir   <= 1'b0;
                            r_dout  <= '0;
                        end else if (w_in_beat) begin
                            r_dout[w_slot*WIDTH +: WIDTH] <= data_in;
                            r_cnt                         <= r_cnt + 1'b1;
                            if (r_cnt == LAST) begin
                                r_state     <= FULL;
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            r_state     <= IDLE;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign dout        = r_dout;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios plus random traffic against a
// queue-based frame model. Timeout scenario runs when SHIFT_DESER_TIMEOUT_EN is defined.
module tb_shift_deserializer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned SIZE    = 3;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DW      = WIDTH * SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ce = 1'b0;
    logic            dir = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WIDTH-1:0] data_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   dout;
    logic            frame_abort;

    int checks   = 0;
    int failures = 0;

    // Reference model: accepted words of the current frame, and the held frame.
    logic [WIDTH-1:0] m_words[$];
    bit               m_dir;
    bit               m_held;
    logic [DW-1:0]    m_frame;
    bit               m_abort;
    int               m_idle;

    shift_deserializer #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .dir         (dir),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit c, input bit iv, input logic [WIDTH-1:0] d,
                              input bit dr, input bit ordy, input bit rs);
        if (rs) begin
            m_words.delete();
            m_held  = 1'b0;
            m_abort = 1'b0;
            m_idle  = 0;
            m_dir   = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (c) begin
                if (m_held) begin
                    if (ordy) m_held = 1'b0;
                end else if (iv) begin
                    if (m_words.size() == 0) m_dir = dr;
                    m_words.push_back(d);
                    m_idle = 0;
                    if (m_words.size() == SIZE) begin
                        for (int k = 0; k < SIZE; k++) begin
                            int s;
                            s = m_dir ? k : SIZE - 1 - k;
                            m_frame[s*WIDTH +: WIDTH] = m_words[k];
                        end
                        m_held = 1'b1;
                        m_words.delete();
                    end
                end else if (m_words.size() > 0) begin
`ifdef SHIFT_DESER_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_words.delete();
                        m_idle  = 0;
                        m_abort = 1'b1;
                    end
`endif
                end
            end
        end
    endtask

    // One clock: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic step(input bit c, input bit iv, input logic [WIDTH-1:0] d,
                        input bit dr, input bit ordy, input bit rs);
        ce        = c;
        in_valid  = iv;
        data_in   = d;
        dir       = dr;
        out_ready = ordy;
        rst       = rs;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, c && !m_held});
        @(posedge clk);
        model_edge(c, iv, d, dr, ordy, rs);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_held});
        chk("frame_abort", {31'd0, frame_abort}, {31'd0, m_abort});
        if (m_held) chk("dout", 32'(dout), 32'(m_frame));
    endtask

    initial begin
        logic [DW-1:0] held_dout;
        int            pulses;

        m_held = 1'b0;
        m_abort = 1'b0;
        m_idle = 0;
        m_frame = '0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

        // dir=1 consecutive words
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("dir1_dout", 32'(dout), 32'h00332211);
        chk("dir1_valid", {31'd0, out_valid}, 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // dir=0 with dir toggling mid-frame
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("dir0_dout", 32'(dout), 32'h00112233);

        // Backpressure: hold frame 5 cycles while input keeps offering words
        held_dout = dout;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0);
            chk("bp_dout_stable", 32'(dout), 32'(held_dout));
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);

        // ce=0 mid-frame freezes everything
        step(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        chk("ce_dout", 32'(dout), 32'h00665544);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Long idle in FILL: abort pulse with the timeout, frame kept without it
        step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (frame_abort) pulses++;
        end
`ifdef SHIFT_DESER_TIMEOUT_EN
        chk("abort_pulses", pulses, 32'd1);
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("post_abort_dout", 32'(dout), 32'h00332211);
`else
        chk("abort_pulses", pulses, 32'd0);
        step(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        chk("held_partial_dout", 32'(dout), 32'h00030201);
`endif
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset while FULL
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rstfull_valid", {31'd0, out_valid}, 32'd0);
        chk("rstfull_dout", 32'(dout), 32'd0);
        chk("rstfull_ready", {31'd0, in_ready}, 32'd1);
        chk("rstfull_abort", {31'd0, frame_abort}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, ($urandom % 4) != 0, 8'($urandom),
                 1'($urandom), 1'($urandom), ($urandom % 97) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
